// File: rtl/grf_sb.sv
// Parametrised general register file with combinational read ports, optional
// write-to-read bypass, optional hardwired zero register and pending-write scoreboard.
module grf_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NREAD*ADDR_W-1:0]  ra,
  output logic [NREAD*DATA_W-1:0]  rd,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic [NREAD-1:0]         busy,
  output logic                     busy_any
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic              wr_ok;
  logic              iss_ok;

  assign wr_ok  = we && !((ZERO_REG != 0) && (wa == '0));
  assign iss_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wa] <= wd;
    end
  end

  // Issue is applied after the writeback clear so a new producer wins over a retiring one.
  always_comb begin
    pend_d = pend_q;
    if (flush) pend_d = '0;
    else if (we) pend_d[wa] = 1'b0;
    if (iss_ok) pend_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign busy_any = |pend_q;

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra_g;
    logic              zero_hit;
    logic              byp_hit;

    assign ra_g     = ra[g*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (ra_g == '0);
    assign byp_hit  = (BYPASS != 0) && we && (wa == ra_g);

    // Reset gates the bypass path too, so rd stays 0 while reset is held.
    assign rd[g*DATA_W +: DATA_W] = (!reset || zero_hit) ? '0 :
                                    byp_hit ? wd : mem_q[ra_g];
    assign busy[g] = pend_q[ra_g] && !byp_hit && !zero_hit;
  end

endmodule
